// File: rtl/disp_scan_ctrl.sv
// Four-digit 7-segment scan controller.
// Arbitrates two signed 9-bit sources round-robin, converts the granted value
// to sign + BCD with a sequential double-dabble, and scans the digits from a
// prescaled tick. seg carries a BCD code (4'hF = minus) for a downstream decoder.
module disp_scan_ctrl #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SCAN_HZ = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [8:0] a_val,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [8:0] b_val,
  output logic       b_ack,
  output logic       busy,
  output logic [3:0] seg,
  output logic [3:0] an
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned VW    = 9;
  localparam int unsigned BW    = 12;
  localparam int unsigned DW    = BW + VW;
  localparam int unsigned STEPS = 9;
  localparam int unsigned SW    = 4;

  typedef enum logic [1:0] {IDLE, GRANT, CONV, LOAD} state_t;

  state_t        state, state_n;
  logic          win_b, win_b_n;
  logic          rr_ptr, rr_ptr_n;   // 1: B wins the next tie
  logic [DW-1:0] dd, dd_n;           // {bcd hund/tens/units, binary}
  logic [SW-1:0] step, step_n;
  logic          neg_s, neg_s_n;
  logic          a_ack_n, b_ack_n, busy_n;
  logic [3:0]    hund, tens, units;
  logic [3:0]    hund_n, tens_n, units_n;
  logic          neg, neg_n;

  logic [VW-1:0] sel_val, mag;
  logic [PW-1:0] pcnt;
  logic          scan_tick_c;
  logic [1:0]    idx, idx_n, idx_eff;
  logic [3:0]    seg_n, an_n;

  // One double-dabble step: bias BCD nibbles >= 5 by 3, then shift left.
  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = x;
    for (int i = 0; i < 3; i++) begin
      if (y[VW + 4*i +: 4] >= 4'd5)
        y[VW + 4*i +: 4] = y[VW + 4*i +: 4] + 4'd3;
    end
    return {y[DW-2:0], 1'b0};
  endfunction

  // Magnitude of the granted source; -256 maps to 256 in 9 bits.
  assign sel_val = win_b ? b_val : a_val;
  assign mag     = sel_val[VW-1] ? VW'(-sel_val) : sel_val;

  // Control FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      win_b  <= 1'b0;
      rr_ptr <= 1'b0;
      dd     <= '0;
      step   <= '0;
      neg_s  <= 1'b0;
      hund   <= '0;
      tens   <= '0;
      units  <= '0;
      neg    <= 1'b0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      win_b  <= win_b_n;
      rr_ptr <= rr_ptr_n;
      dd     <= dd_n;
      step   <= step_n;
      neg_s  <= neg_s_n;
      hund   <= hund_n;
      tens   <= tens_n;
      units  <= units_n;
      neg    <= neg_n;
      a_ack  <= a_ack_n;
      b_ack  <= b_ack_n;
      busy   <= busy_n;
    end
  end

  // Next state: arbitrate, capture on the ack cycle, convert, load atomically.
  always_comb begin
    state_n  = state;
    win_b_n  = win_b;
    rr_ptr_n = rr_ptr;
    dd_n     = dd;
    step_n   = step;
    neg_s_n  = neg_s;
    hund_n   = hund;
    tens_n   = tens;
    units_n  = units;
    neg_n    = neg;
    a_ack_n  = 1'b0;
    b_ack_n  = 1'b0;
    busy_n   = busy;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (a_req || b_req) begin
          state_n = GRANT;
          win_b_n = b_req && (!a_req || rr_ptr);
          a_ack_n = !win_b_n;
          b_ack_n = win_b_n;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
        dd_n     = DW'(mag);
        neg_s_n  = sel_val[VW-1];
        step_n   = '0;
        rr_ptr_n = !win_b;
        state_n  = CONV;
      end
      CONV: begin
        dd_n   = dd_step(dd);
        step_n = step + SW'(1);
        if (step == SW'(STEPS - 1))
          state_n = LOAD;
      end
      LOAD: begin
        hund_n  = dd[VW + 8 +: 4];
        tens_n  = dd[VW + 4 +: 4];
        units_n = dd[VW +: 4];
        neg_n   = neg_s;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Prescaler: free-running 0..DIV-1, tick on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pcnt <= '0;
    else if (pcnt == PW'(DIV - 1))
      pcnt <= '0;
    else
      pcnt <= pcnt + PW'(1);
  end

  assign scan_tick_c = (pcnt == PW'(DIV - 1));

  // Scan step: a sign slot whose sign has since cleared falls back to units.
  always_comb begin
    seg_n   = seg;
    an_n    = an;
    idx_n   = idx;
    idx_eff = idx;
    if (idx == 2'd3 && !neg)
      idx_eff = 2'd0;
    if (scan_tick_c) begin
      case (idx_eff)
        2'd0: begin seg_n = units; an_n = 4'b1110; idx_n = 2'd1; end
        2'd1: begin seg_n = tens;  an_n = 4'b1101; idx_n = 2'd2; end
        2'd2: begin seg_n = hund;  an_n = 4'b1011; idx_n = neg ? 2'd3 : 2'd0; end
        default: begin seg_n = 4'hF; an_n = 4'b0111; idx_n = 2'd0; end
      endcase
    end
  end

  // Scan registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= '0;
      an  <= 4'b1111;
      idx <= '0;
    end else begin
      seg <= seg_n;
      an  <= an_n;
      idx <= idx_n;
    end
  end

endmodule
